// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - grant-select encoding and host FSM state codes for the data-RAM arbiter
package dram_arbiter_pkg;

   // Which requester owns the RAM port this cycle
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_P    = 2'd1,
      GNT_W    = 2'd2,
      GNT_H    = 2'd3
   } grant_t;

   // Host/debug port transaction states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HREAD = 2'd1,
      HDONE = 2'd2
   } host_state_t;

   localparam logic [1:0] WBUF_DEPTH = 2'd2;

endpackage

// File: rtl/dram_write_buffer.sv
// rtl/dram_write_buffer.sv - 2-entry posted-write FIFO with youngest-match address lookup
module dram_write_buffer
   import dram_arbiter_pkg::*;
#(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enq,
   input  logic [A_WIDTH-1:0] enq_addr,
   input  logic [D_WIDTH-1:0] enq_data,
   input  logic               deq,
   output logic [A_WIDTH-1:0] head_addr,
   output logic [D_WIDTH-1:0] head_data,
   output logic [1:0]         count,
   output logic               full,
   input  logic [A_WIDTH-1:0] q_addr,
   output logic               hit,
   output logic [D_WIDTH-1:0] hit_data
);

   // Slot 0 is always the head; slot 1 is the tail when two entries are held.
   logic [A_WIDTH-1:0] addr0, addr1;
   logic [D_WIDTH-1:0] data0, data1;
   logic [1:0]         count_q, count_next;

   assign head_addr = addr0;
   assign head_data = data0;
   assign count     = count_q;

   // Occupancy after this cycle's enqueue/dequeue
   always_comb begin
      count_next = count_q;
      if (enq && !deq)
         count_next = count_q + 2'd1;
      else if (!enq && deq)
         count_next = count_q - 2'd1;
   end

   // FIFO storage as a two-slot shift register; full is registered from the next count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr0   <= '0;
         data0   <= '0;
         addr1   <= '0;
         data1   <= '0;
         count_q <= 2'd0;
         full    <= 1'b0;
      end else begin
         case ({enq, deq})
            2'b10: begin
               if (count_q == 2'd0) begin
                  addr0 <= enq_addr;
                  data0 <= enq_data;
               end else begin
                  addr1 <= enq_addr;
                  data1 <= enq_data;
               end
            end
            2'b01: begin
               addr0 <= addr1;
               data0 <= data1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  addr0 <= enq_addr;
                  data0 <= enq_data;
               end else begin
                  addr0 <= addr1;
                  data0 <= data1;
                  addr1 <= enq_addr;
                  data1 <= enq_data;
               end
            end
            default: ;
         endcase
         count_q <= count_next;
         full    <= (count_next == WBUF_DEPTH);
      end
   end

   // Associative lookup; the tail test comes last so the younger entry wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      if (count_q >= 2'd1 && addr0 == q_addr) begin
         hit      = 1'b1;
         hit_data = data0;
      end
      if (count_q == 2'd2 && addr1 == q_addr) begin
         hit      = 1'b1;
         hit_data = data1;
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - fixed-priority data-RAM arbiter for pipeline read, buffered write and host port
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rce,
   input  logic [A_WIDTH-1:0] ra,
   output logic [D_WIDTH-1:0] rd,
   input  logic               wce,
   input  logic [A_WIDTH-1:0] wa,
   input  logic [D_WIDTH-1:0] wd,
   output logic               wfull,
   output logic               overflow,
   input  logic               hreq,
   input  logic               hwe,
   input  logic [A_WIDTH-1:0] ha,
   input  logic [D_WIDTH-1:0] hwd,
   output logic               hack,
   output logic [D_WIDTH-1:0] hrd,
   output logic               mce,
   output logic               mwe,
   output logic [A_WIDTH-1:0] ma,
   output logic [D_WIDTH-1:0] mwd,
   input  logic [D_WIDTH-1:0] mrd
);

   grant_t             grant;
   host_state_t        state;
   logic               enq;
   logic [A_WIDTH-1:0] head_addr;
   logic [D_WIDTH-1:0] head_data;
   logic [1:0]         wb_count;
   logic               wb_hit;
   logic [D_WIDTH-1:0] wb_hit_data;
   logic               fwd_hit_d, fwd_hit_q;
   logic [D_WIDTH-1:0] fwd_data_d, fwd_data_q;
   logic               rd_pend_q;
   logic [D_WIDTH-1:0] rd_hold_q;

   // A write arriving while the buffer is full is dropped
   assign enq = wce && !wfull;

   dram_write_buffer #(
      .A_WIDTH(A_WIDTH),
      .D_WIDTH(D_WIDTH)
   ) u_wbuf (
      .clk      (clk),
      .reset    (reset),
      .enq      (enq),
      .enq_addr (wa),
      .enq_data (wd),
      .deq      (grant == GNT_W),
      .head_addr(head_addr),
      .head_data(head_data),
      .count    (wb_count),
      .full     (wfull),
      .q_addr   (ra),
      .hit      (wb_hit),
      .hit_data (wb_hit_data)
   );

   // Fixed-priority grant; holding reset low parks the port so mce/mwe stay 0
   always_comb begin
      grant = GNT_NONE;
      if (reset) begin
         if (rce)
            grant = GNT_P;
         else if (wb_count != 2'd0)
            grant = GNT_W;
         else if (state == IDLE && hreq)
            grant = GNT_H;
      end
   end

   // RAM port driven straight from the grant
   always_comb begin
      mce = 1'b0;
      mwe = 1'b0;
      ma  = '0;
      mwd = '0;
      case (grant)
         GNT_P: begin
            mce = 1'b1;
            ma  = ra;
         end
         GNT_W: begin
            mce = 1'b1;
            mwe = 1'b1;
            ma  = head_addr;
            mwd = head_data;
         end
         GNT_H: begin
            mce = 1'b1;
            mwe = hwe;
            ma  = ha;
            mwd = hwd;
         end
         default: ;
      endcase
   end

   // Forwarding source for a read: same-cycle write first, then youngest buffered entry
   always_comb begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
      if (enq && wa == ra) begin
         fwd_hit_d  = 1'b1;
         fwd_data_d = wd;
      end else if (wb_hit) begin
         fwd_hit_d  = 1'b1;
         fwd_data_d = wb_hit_data;
      end
   end

   // Capture the forwarding decision in the rce cycle and remember the last delivered word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
         rd_pend_q  <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         if (rce) begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
         end
         rd_pend_q <= rce;
         rd_hold_q <= rd;
      end
   end

   // RAM data arrives the cycle after rce, so rd is selected here rather than re-registered
   assign rd = rd_pend_q ? (fwd_hit_q ? fwd_data_q : mrd) : rd_hold_q;

   // Sticky record of a write offered to a full buffer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (wce && wfull)
         overflow <= 1'b1;
   end

   // Host FSM with registered hack/hrd
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         hack  <= 1'b0;
         hrd   <= '0;
      end else begin
         case (state)
            IDLE: begin
               hack <= 1'b0;
               if (grant == GNT_H) begin
                  if (hwe) begin
                     state <= HDONE;
                     hack  <= 1'b1;
                  end else begin
                     state <= HREAD;
                  end
               end
            end
            HREAD: begin
               hrd   <= mrd;
               hack  <= 1'b1;
               state <= HDONE;
            end
            HDONE: begin
               hack  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               hack  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rce;
   logic [11:0] ra;
   logic [7:0]  rd;
   logic        wce;
   logic [11:0] wa;
   logic [7:0]  wd;
   logic        wfull;
   logic        overflow;
   logic        hreq;
   logic        hwe;
   logic [11:0] ha;
   logic [7:0]  hwd;
   logic        hack;
   logic [7:0]  hrd;
   logic        mce;
   logic        mwe;
   logic [11:0] ma;
   logic [7:0]  mwd;
   logic [7:0]  mrd;

   logic [7:0]  mem [0:4095];
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   dram_arbiter #(.A_WIDTH(12), .D_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .rce(rce), .ra(ra), .rd(rd),
      .wce(wce), .wa(wa), .wd(wd), .wfull(wfull), .overflow(overflow),
      .hreq(hreq), .hwe(hwe), .ha(ha), .hwd(hwd), .hack(hack), .hrd(hrd),
      .mce(mce), .mwe(mwe), .ma(ma), .mwd(mwd), .mrd(mrd)
   );

   // Synchronous RAM model
   always @(posedge clk) begin
      if (mce) begin
         if (mwe) mem[ma] <= mwd;
         else     mrd <= mem[ma];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      rce = 1'b1; ra = 12'd5;
      #12;
      n_cmp++; if (mce !== 1'b0) begin n_fail++; $display("FAIL reset_mce: got %b want 0", mce); end
      n_cmp++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL reset_mwe: got %b want 0", mwe); end
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h want 00", rd); end
      n_cmp++; if (hrd !== 8'h00) begin n_fail++; $display("FAIL reset_hrd: got %h want 00", hrd); end
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL reset_hack: got %b want 0", hack); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      n_cmp++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b want 0", wfull); end
      rce = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_read;
      rce = 1'b1; ra = 12'd5;
      #1;
      n_cmp++; if (mce !== 1'b1) begin n_fail++; $display("FAIL read_mce: got %b want 1", mce); end
      n_cmp++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL read_mwe: got %b want 0", mwe); end
      n_cmp++; if (ma !== 12'd5) begin n_fail++; $display("FAIL read_ma: got %h want 005", ma); end
      tick();
      rce = 1'b0;
      #1;
      n_cmp++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL read_rd: got %h want 3c", rd); end
      tick();
      n_cmp++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL read_rd_hold: got %h want 3c", rd); end
      n_cmp++; if (mce !== 1'b0) begin n_fail++; $display("FAIL read_idle_mce: got %b want 0", mce); end
   endtask

   task automatic test_forward_same_cycle;
      wce = 1'b1; wa = 12'd7; wd = 8'h11;
      rce = 1'b1; ra = 12'd7;
      tick();
      wce = 1'b0; rce = 1'b0;
      #1;
      n_cmp++; if (rd !== 8'h11) begin n_fail++; $display("FAIL fwd_rd: got %h want 11", rd); end
      n_cmp++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL fwd_drain_mwe: got %b want 1", mwe); end
      n_cmp++; if (ma !== 12'd7) begin n_fail++; $display("FAIL fwd_drain_ma: got %h want 007", ma); end
      n_cmp++; if (mwd !== 8'h11) begin n_fail++; $display("FAIL fwd_drain_mwd: got %h want 11", mwd); end
      tick();
      n_cmp++; if (mem[7] !== 8'h11) begin n_fail++; $display("FAIL fwd_mem7: got %h want 11", mem[7]); end
      n_cmp++; if (mce !== 1'b0) begin n_fail++; $display("FAIL fwd_empty_mce: got %b want 0", mce); end
   endtask

   task automatic test_overflow;
      rce = 1'b1; ra = 12'd0;
      wce = 1'b1; wa = 12'd9; wd = 8'h01;
      tick();
      wd = 8'h02;
      tick();
      n_cmp++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL ovf_wfull: got %b want 1", wfull); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      wd = 8'h03;
      tick();
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      n_cmp++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL ovf_still_full: got %b want 1", wfull); end
      wce = 1'b0; ra = 12'd9;
      tick();
      rce = 1'b0;
      #1;
      n_cmp++; if (rd !== 8'h02) begin n_fail++; $display("FAIL ovf_fwd_tail: got %h want 02", rd); end
      n_cmp++; if (mwe !== 1'b1 || ma !== 12'd9 || mwd !== 8'h01) begin n_fail++; $display("FAIL ovf_drain1: got mwe=%b ma=%h mwd=%h want 1/009/01", mwe, ma, mwd); end
      tick();
      n_cmp++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL ovf_wfull_clear: got %b want 0", wfull); end
      n_cmp++; if (mwe !== 1'b1 || ma !== 12'd9 || mwd !== 8'h02) begin n_fail++; $display("FAIL ovf_drain2: got mwe=%b ma=%h mwd=%h want 1/009/02", mwe, ma, mwd); end
      tick();
      n_cmp++; if (mem[9] !== 8'h02) begin n_fail++; $display("FAIL ovf_mem9: got %h want 02", mem[9]); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_host_read;
      bit got;
      hreq = 1'b1; hwe = 1'b0; ha = 12'd3;
      #1;
      n_cmp++; if (mce !== 1'b1 || mwe !== 1'b0 || ma !== 12'd3) begin n_fail++; $display("FAIL hrd_grant: got mce=%b mwe=%b ma=%h want 1/0/003", mce, mwe, ma); end
      tick();
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL hrd_hack_early: got %b want 0", hack); end
      tick();
      n_cmp++; if (hack !== 1'b1) begin n_fail++; $display("FAIL hrd_hack: got %b want 1", hack); end
      n_cmp++; if (hrd !== 8'h5A) begin n_fail++; $display("FAIL hrd_data: got %h want 5a", hrd); end
      hreq = 1'b0;
      tick();
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL hrd_hack_pulse: got %b want 0", hack); end

      // host request while the pipeline is busy and a write is posted
      hreq = 1'b1; ha = 12'd3;
      rce = 1'b1; ra = 12'd0;
      wce = 1'b1; wa = 12'd20; wd = 8'h77;
      #1;
      n_cmp++; if (mwe !== 1'b0 || ma !== 12'd0) begin n_fail++; $display("FAIL hbusy_p: got mwe=%b ma=%h want 0/000", mwe, ma); end
      tick();
      rce = 1'b0; wce = 1'b0;
      #1;
      n_cmp++; if (mwe !== 1'b1 || ma !== 12'd20 || mwd !== 8'h77) begin n_fail++; $display("FAIL hbusy_drain: got mwe=%b ma=%h mwd=%h want 1/014/77", mwe, ma, mwd); end
      tick();
      n_cmp++; if (mce !== 1'b1 || mwe !== 1'b0 || ma !== 12'd3) begin n_fail++; $display("FAIL hbusy_grant: got mce=%b mwe=%b ma=%h want 1/0/003", mce, mwe, ma); end
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (hack) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL hbusy_hack_timeout: got %b want 1", got); end
      n_cmp++; if (hrd !== 8'h5A) begin n_fail++; $display("FAIL hbusy_hrd: got %h want 5a", hrd); end
      hreq = 1'b0;
      tick();
   endtask

   task automatic test_host_write;
      hreq = 1'b1; hwe = 1'b1; ha = 12'd4; hwd = 8'hAA;
      #1;
      n_cmp++; if (mce !== 1'b1 || mwe !== 1'b1 || ma !== 12'd4 || mwd !== 8'hAA) begin n_fail++; $display("FAIL hwr_grant: got mce=%b mwe=%b ma=%h mwd=%h want 1/1/004/aa", mce, mwe, ma, mwd); end
      tick();
      n_cmp++; if (hack !== 1'b1) begin n_fail++; $display("FAIL hwr_hack: got %b want 1", hack); end
      hreq = 1'b0; hwe = 1'b0;
      tick();
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL hwr_hack_pulse: got %b want 0", hack); end
      rce = 1'b1; ra = 12'd4;
      tick();
      rce = 1'b0;
      #1;
      n_cmp++; if (rd !== 8'hAA) begin n_fail++; $display("FAIL hwr_readback: got %h want aa", rd); end
      tick();
   endtask

   task automatic test_reset_mid_host;
      hreq = 1'b1; hwe = 1'b0; ha = 12'd3;
      tick();
      reset = 1'b0;
      hreq = 1'b0;
      #1;
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL rmid_hack: got %b want 0", hack); end
      n_cmp++; if (hrd !== 8'h00) begin n_fail++; $display("FAIL rmid_hrd: got %h want 00", hrd); end
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rmid_rd: got %h want 00", rd); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
      n_cmp++; if (mce !== 1'b0 || mwe !== 1'b0) begin n_fail++; $display("FAIL rmid_mce: got mce=%b mwe=%b want 0/0", mce, mwe); end
      @(negedge clk);
      reset = 1'b1;
      tick();
      n_cmp++; if (hack !== 1'b0) begin n_fail++; $display("FAIL rmid_no_hack: got %b want 0", hack); end
      hreq = 1'b1; hwe = 1'b0; ha = 12'd3;
      #1;
      n_cmp++; if (mce !== 1'b1 || ma !== 12'd3) begin n_fail++; $display("FAIL rmid_idle_regrant: got mce=%b ma=%h want 1/003", mce, ma); end
      tick();
      tick();
      n_cmp++; if (hack !== 1'b1 || hrd !== 8'h5A) begin n_fail++; $display("FAIL rmid_rerequest: got hack=%b hrd=%h want 1/5a", hack, hrd); end
      hreq = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[5] = 8'h3C;
      mem[3] = 8'h5A;
      mrd = 8'h00;
      rce = 1'b0; ra = '0;
      wce = 1'b0; wa = '0; wd = '0;
      hreq = 1'b0; hwe = 1'b0; ha = '0; hwd = '0;

      test_reset();
      test_read();
      test_forward_same_cycle();
      test_overflow();
      test_host_read();
      test_host_write();
      test_reset_mid_host();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Owns the single synchronous data-RAM port and shares it among three requesters:
  - pipeline read (P), driven by the D-fetch stage;
  - pipeline write (W), driven by the writeback stage and posted through a 2-entry write buffer;
  - host/debug port (H), using a req/ack handshake for program load and memory dump.
- Pipeline reads are never stalled.
- Writes are buffered and forwarded to later reads.
- Host accesses use only idle cycles.

Parameters:
- A_WIDTH, 12, data address width
- D_WIDTH, 8, data word width

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous active-low reset (asserted at 0)
- rce  input  1  pipeline read request this cycle
- ra  input  A_WIDTH  pipeline read address
- rd  output  D_WIDTH  pipeline read data, valid the cycle after rce
- wce  input  1  pipeline write request
- wa  input  A_WIDTH  pipeline write address
- wd  input  D_WIDTH  pipeline write data
- wfull  output  1  write buffer holds 2 entries; pipeline must not assert wce
- overflow  output  1  sticky: wce was seen while wfull
- hreq  input  1  host request; held until hack
- hwe  input  1  host write (1) / read (0)
- ha  input  A_WIDTH  host address
- hwd  input  D_WIDTH  host write data
- hack  output  1  one-cycle completion pulse
- hrd  output  D_WIDTH  host read data, valid with hack
- mce  output  1  RAM enable
- mwe  output  1  RAM write enable
- ma  output  A_WIDTH  RAM address
- mwd  output  D_WIDTH  RAM write data
- mrd  input  D_WIDTH  RAM read data, one cycle after mce with !mwe

Behaviour:
- Reset (reset=0, asynchronous):
  - write buffer emptied;
  - rd, hrd = 0; hack, overflow = 0; FSM to IDLE;
  - mce and mwe forced to 0 combinationally while reset is low.
- Per-cycle grant, fixed priority; RAM outputs are combinational from the grant:
  1. rce: RAM read at ra.
  2. Else, if the buffer is non-empty: write the head entry (mwe=1) and dequeue.
  3. Else, if FSM is IDLE and hreq: host access.
  4. Else: mce=0.
- Write buffer:
  - 2-entry FIFO.
  - wce when not full enqueues {wa, wd}.
  - Enqueue and dequeue in the same cycle are legal; count is unchanged.
  - wce while full: write dropped, overflow set to 1 until reset.
  - wfull is registered and equals (count==2).
- Read forwarding, resolved in the rce cycle and applied to rd the next cycle:
  - Precedence, youngest first: a same-cycle wce with wa==ra; then the buffer tail entry matching ra; then the buffer head entry matching ra; else mrd.
  - The forwarding select and data are registered.
  - rd holds its value in cycles with no preceding rce.
- Host FSM:
  - States: IDLE, HREAD, HDONE.
  - IDLE→HDONE: host write granted; RAM written; hack=1 next cycle.
  - IDLE→HREAD: host read granted; next cycle hrd<=mrd and hack=1.
  - HREAD→HDONE: hrd captured, hack=1.
  - HDONE→IDLE: unconditional; hreq must be deasserted or re-presented as a new transaction.
  - A host grant occurs only when the buffer is empty, so host reads never need forwarding.
  - A host request may wait indefinitely while P or W keep the port busy; this is accepted (host is used only while the core is halted).
- Reset mid-transaction: a pending host operation is abandoned and no hack is issued; the host must re-request.

Decomposition:
- Constants.v gains the grant-select encoding: GNT_NONE, GNT_P, GNT_W, GNT_H, and the host FSM state codes.
- One sub-module, dram_write_buffer:
  - 2-entry FIFO with enqueue/dequeue, head outputs, count/full;
  - associative lookup port returning hit plus youngest matching data for a query address.
- The arbiter instantiates it and keeps grant, forwarding and host FSM logic.

Test Plan:
- Reset, then rce with ra=5 and RAM preloaded mem[5]=0x3C → next cycle rd=0x3C; mce=1, mwe=0 in the rce cycle.
- wce with wa=7, wd=0x11, and rce with ra=7 in the same cycle → rd=0x11 next cycle. Buffer drains in the next rce-free cycle: mwe=1, ma=7, mwd=0x11.
- Two wce (addr 9: 0x01, then 0x02) while rce is held high every cycle → wfull=1 after the second. A third wce sets overflow=1, and the buffer still holds two entries. rce at addr 9 → rd=0x02.
- hreq read at ha=3 with the buffer empty and no rce → hack pulses 2 cycles after the grant cycle with hrd=mem[3]. hreq with a non-empty buffer → no grant until the drain completes.
- Host write ha=4, hwd=0xAA, then pipeline read at 4 → rd=0xAA. Assert reset low during HREAD → no hack; FSM in IDLE; all outputs 0.
